// File: rtl/uart_rx_axis_if.sv
// Byte stream bundle between the UART receiver and its consumer.
// Latency: none, wires only.
// Backpressure: tready from the slave side qualifies tvalid from the master side.
// Signals: tdata (8-bit byte), tvalid (byte available), tready (consumer accepts).
interface uart_rx_axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_axis.sv
// UART 8N1 receiver (LSB first) feeding a single-entry stream holding register.
// Latency: rxd falling edge to m.tvalid = 2 + CLK_DIV/2 + 9*CLK_DIV + 1 cycles.
// Backpressure: one byte held; a byte completing while the held one is unaccepted overwrites it and pulses rx_overrun_error.
// Ports: clk, rstn (sync, active-low), rxd (async serial in, idle high),
//        m (stream master: tdata/tvalid/tready), rx_busy (frame in progress),
//        rx_overrun_error / rx_frame_error (one-cycle status pulses).
module uart_rx_axis #(
  parameter int CLK_DIV = 868
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rxd,
  uart_rx_axis_if.master m,
  output logic           rx_busy,
  output logic           rx_overrun_error,
  output logic           rx_frame_error
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rxd_m, rxd_s;
  logic          tick;
  logic          byte_done;
  logic          frame_bad;

  assign tick    = (cnt == '0);
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    byte_done   = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          // Half-bit load puts every later sample in the middle of its bit.
          cnt_nxt     = HALF_LOAD;
          bit_idx_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rxd_s) begin
            cnt_nxt   = FULL_LOAD;
            state_nxt = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          // Line is LSB first, so shifting in at the MSB leaves bit 0 at the bottom after 8 bits.
          shreg_nxt   = {rxd_s, shreg[7:1]};
          cnt_nxt     = FULL_LOAD;
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          // Leave mid stop bit so a back-to-back start edge is not missed.
          state_nxt = IDLE;
          if (rxd_s) begin
            byte_done = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_m            <= 1'b1;
      rxd_s            <= 1'b1;
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      shreg            <= '0;
      m.tdata          <= '0;
      m.tvalid         <= 1'b0;
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= 1'b0;
    end else begin
      rxd_m            <= rxd;
      rxd_s            <= rxd_m;
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      bit_idx          <= bit_idx_nxt;
      shreg            <= shreg_nxt;
      rx_frame_error   <= frame_bad;
      // A handshake in the completion cycle frees the slot, so only a stalled consumer overruns.
      rx_overrun_error <= byte_done && m.tvalid && !m.tready;
      if (byte_done) begin
        m.tdata  <= shreg;
        m.tvalid <= 1'b1;
      end else if (m.tvalid && m.tready) begin
        m.tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis at CLK_DIV=8: reset values, table of frames,
// directed multi-cycle corner cases and a randomized run against a transaction model.
module tb_uart_rx_axis;
  localparam int DIV    = 8;
  localparam int FALL2S = 2 + DIV / 2 + 9 * DIV;  // rxd fall to stop-bit sample cycle
  localparam int FRAME  = 10 * DIV;
  localparam int NR     = 30;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rxd  = 1'b1;
  logic rx_busy, rx_overrun_error, rx_frame_error;
  int   cyc  = 0;

  uart_rx_axis_if axis ();

  uart_rx_axis #(.CLK_DIV(DIV)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .rxd              (rxd),
    .m                (axis),
    .rx_busy          (rx_busy),
    .rx_overrun_error (rx_overrun_error),
    .rx_frame_error   (rx_frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Observation log, sampled on the falling edge.
  int         hs_cyc[$];
  logic [7:0] hs_dat[$];
  int fe_cnt, ov_cnt, vld_cnt, vld_first, busy_cnt, busy_first, busy_last;

  task automatic clear_mon();
    hs_cyc.delete();
    hs_dat.delete();
    fe_cnt = 0; ov_cnt = 0; vld_cnt = 0; busy_cnt = 0;
    vld_first = -1; busy_first = -1; busy_last = -1;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (axis.tvalid && axis.tready) begin
        hs_cyc.push_back(cyc);
        hs_dat.push_back(axis.tdata);
      end
      if (rx_frame_error) fe_cnt++;
      if (rx_overrun_error) ov_cnt++;
      if (axis.tvalid) begin
        vld_cnt++;
        if (vld_first < 0) vld_first = cyc;
      end
      if (rx_busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1);
  end

  // All stimulus tasks start and end at 1 time unit after a rising edge.
  int last_fall;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    idle(DIV);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    last_fall = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_cnt;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;
  vec_t vt[6];

  // Random run state and model.
  logic [7:0] r_dat[NR];
  logic       r_stop[NR];
  int         r_gap[NR];
  bit         tr_log[4096];
  int         total, base;

  function automatic bit tr_at(input int t);
    int k;
    k = t - base;
    return (k < total) ? tr_log[k] : 1'b1;
  endfunction

  int         good_c[$];
  logic [7:0] good_d[$];
  int         exp_t[$];
  logic [7:0] exp_d[$];
  int         exp_fe, exp_ov, off, lim, f;
  bit         found;

  initial begin
    vt[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vt[1] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vt[2] = '{8'h80, 1'b1, 1, 8'h80, 0};
    vt[3] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vt[4] = '{8'hC3, 1'b0, 0, 8'h00, 1};
    vt[5] = '{8'h6A, 1'b1, 1, 8'h6A, 0};

    axis.tready = 1'b0;
    @(posedge clk); #1;
    idle(3);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_overrun", rx_overrun_error, 0);
    chk("rst_frame_err", rx_frame_error, 0);
    rstn = 1'b1;
    idle(3);

    // Single byte with exact timing.
    clear_mon();
    axis.tready = 1'b1;
    send_frame(8'hA5, 1'b1);
    f = last_fall;
    idle(20);
    chk("sb_count", hs_dat.size(), 1);
    if (hs_dat.size() > 0) chk("sb_data", hs_dat[0], 'hA5);
    chk("sb_vld_cycle", vld_first - f, FALL2S + 1);
    chk("sb_vld_width", vld_cnt, 1);
    chk("sb_busy_rise", busy_first - f, 3);
    chk("sb_busy_fall", busy_last - f, FALL2S);
    chk("sb_frame_err", fe_cnt, 0);
    chk("sb_overrun", ov_cnt, 0);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      axis.tready = 1'b1;
      send_frame(vt[i].data, vt[i].stop);
      idle(12);
      chk($sformatf("vec%0d_count", i), hs_dat.size(), vt[i].exp_cnt);
      if (vt[i].exp_cnt > 0 && hs_dat.size() > 0)
        chk($sformatf("vec%0d_data", i), hs_dat[0], vt[i].exp_data);
      chk($sformatf("vec%0d_frame_err", i), fe_cnt, vt[i].exp_fe);
      chk($sformatf("vec%0d_overrun", i), ov_cnt, 0);
    end

    // Overrun: two back-to-back frames with the consumer stalled.
    clear_mon();
    axis.tready = 1'b0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h0D, 1'b1);
    idle(10);
    chk("ov_pulses", ov_cnt, 1);
    chk("ov_tvalid", axis.tvalid, 1);
    chk("ov_tdata", axis.tdata, 'h0D);
    chk("ov_no_hs", hs_dat.size(), 0);
    axis.tready = 1'b1;
    idle(1);
    axis.tready = 1'b0;
    idle(2);
    chk("ov_tvalid_cleared", axis.tvalid, 0);
    chk("ov_hs_count", hs_dat.size(), 1);
    if (hs_dat.size() > 0) chk("ov_hs_data", hs_dat[0], 'h0D);

    // Frame error then a good byte.
    clear_mon();
    axis.tready = 1'b1;
    send_frame(8'h3C, 1'b0);
    idle(20);
    chk("fe_pulses", fe_cnt, 1);
    chk("fe_no_valid", vld_cnt, 0);
    send_frame(8'h55, 1'b1);
    idle(20);
    chk("fe_next_count", hs_dat.size(), 1);
    if (hs_dat.size() > 0) chk("fe_next_data", hs_dat[0], 'h55);
    chk("fe_total_pulses", fe_cnt, 1);
    chk("fe_overrun", ov_cnt, 0);

    // Glitch: two low cycles on rxd.
    clear_mon();
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(20);
    chk("gl_busy_cycles", busy_cnt, DIV / 2);
    chk("gl_no_valid", vld_cnt, 0);
    chk("gl_frame_err", fe_cnt, 0);
    chk("gl_overrun", ov_cnt, 0);

    // Accept of the held byte in the very cycle the next byte completes.
    clear_mon();
    axis.tready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(4);
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle(FALL2S);
        axis.tready = 1'b1;
        idle(1);
        axis.tready = 1'b0;
      end
    join
    idle(4);
    chk("sim_overrun", ov_cnt, 0);
    chk("sim_tvalid", axis.tvalid, 1);
    chk("sim_tdata", axis.tdata, 'h22);
    chk("sim_hs_count", hs_dat.size(), 1);
    if (hs_dat.size() > 0) chk("sim_hs_data", hs_dat[0], 'h11);
    axis.tready = 1'b1;
    idle(3);

    // Reset in the middle of a frame with a byte pending.
    clear_mon();
    axis.tready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(4);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(5 * DIV + 2);
        rstn = 1'b0;
      end
    join
    idle(4);
    chk("mr_tvalid", axis.tvalid, 0);
    chk("mr_tdata", axis.tdata, 0);
    chk("mr_busy", rx_busy, 0);
    chk("mr_overrun", ov_cnt, 0);
    chk("mr_frame_err", fe_cnt, 0);
    rstn = 1'b1;
    idle(2);
    clear_mon();
    axis.tready = 1'b1;
    send_frame(8'h7E, 1'b1);
    idle(20);
    chk("mr_next_count", hs_dat.size(), 1);
    if (hs_dat.size() > 0) chk("mr_next_data", hs_dat[0], 'h7E);
    chk("mr_next_frame_err", fe_cnt, 0);

    // Randomized frames, gaps and consumer stalls.
    total = 0;
    for (int i = 0; i < NR; i++) begin
      r_dat[i]  = 8'($urandom);
      r_stop[i] = ($urandom_range(0, 7) != 0);
      // A bad stop bit leaves the line low past the sample point; give the receiver a bit time to recover.
      r_gap[i]  = r_stop[i] ? int'($urandom_range(0, 10)) : int'($urandom_range(DIV, DIV + 10));
      total    += FRAME + r_gap[i];
    end
    clear_mon();
    base = cyc;
    fork
      for (int i = 0; i < NR; i++) begin
        send_frame(r_dat[i], r_stop[i]);
        idle(r_gap[i]);
      end
      for (int j = 0; j < total; j++) begin
        axis.tready = ($urandom_range(0, 3) == 0);
        tr_log[j]   = axis.tready;
        idle(1);
      end
    join
    axis.tready = 1'b1;
    idle(100);

    // Model: each good byte is valid from the cycle after its stop sample;
    // it is taken at the first ready cycle up to and including the next good
    // byte's stop sample, otherwise it is overwritten.
    exp_fe = 0; exp_ov = 0; off = 0;
    for (int i = 0; i < NR; i++) begin
      if (r_stop[i]) begin
        good_c.push_back(base + off + FALL2S);
        good_d.push_back(r_dat[i]);
      end else begin
        exp_fe++;
      end
      off += FRAME + r_gap[i];
    end
    for (int j = 0; j < good_c.size(); j++) begin
      lim   = (j + 1 < good_c.size()) ? good_c[j + 1] : good_c[j] + 200;
      found = 1'b0;
      for (int t = good_c[j] + 1; t <= lim && !found; t++) begin
        if (tr_at(t)) begin
          found = 1'b1;
          exp_t.push_back(t);
          exp_d.push_back(good_d[j]);
        end
      end
      if (!found) exp_ov++;
    end
    chk("rnd_count", hs_dat.size(), exp_d.size());
    chk("rnd_overrun", ov_cnt, exp_ov);
    chk("rnd_frame_err", fe_cnt, exp_fe);
    for (int i = 0; i < hs_dat.size() && i < exp_d.size(); i++) begin
      chk($sformatf("rnd_data%0d", i), hs_dat[i], exp_d[i]);
      chk($sformatf("rnd_cycle%0d", i), hs_cyc[i] - base, exp_t[i] - base);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

UART receiver that deserialises the asynchronous `rxd` line (8N1, LSB first) into bytes and presents them on an AXI4-Stream master port. It sits directly upstream of the UART-to-I2C command bridge, supplying its `m_tdata`/`m_tvalid`/`m_tready` byte stream and its `rx_busy`, `rx_overrun_error` and `rx_frame_error` status inputs. The output is a single-entry holding register, so the bridge can stall for up to one byte time without losing data.

## Interface
- `CLK_DIV`, default 868: clk cycles per bit (100 MHz / 115200). Minimum 4. Counter width `$clog2(CLK_DIV)`.
- `clk  in  1`: clock; all logic on posedge.
- `rstn  in  1`: reset, synchronous, active-low.
- `rxd  in  1`: asynchronous serial input; idle high.
- `m_tdata  out  8`: received byte.
- `m_tvalid  out  1`: byte available; held until accepted.
- `m_tready  in  1`: consumer accepts the byte when high together with `m_tvalid`.
- `rx_busy  out  1`: frame reception in progress.
- `rx_overrun_error  out  1`: one-cycle pulse when an unaccepted byte is overwritten.
- `rx_frame_error  out  1`: one-cycle pulse when the stop bit samples 0.

## Operation
- **Synchroniser:** 2-flop synchroniser on `rxd` produces `rxd_s`. Both flops reset to 1. `rxd_s` lags `rxd` by 2 cycles.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** if `rxd_s`=0, load counter with `CLK_DIV/2-1` (floor), clear the bit index, and go to START.
- **START:** on counter=0, sample `rxd_s`.
  - If 0: reload counter with `CLK_DIV-1` and go to DATA.
  - If 1 (glitch): return to IDLE. No output, no error.
- **DATA:** on each counter=0, shift `rxd_s` into the MSB of an 8-bit shift register (LSB-first line order) and reload counter with `CLK_DIV-1`. After bit index 7, go to STOP.
- **STOP:** on counter=0, sample `rxd_s`, then go to IDLE in the same cycle, which is mid stop-bit.
  - If 1: the byte is complete; load it into the output register.
  - If 0: pulse `rx_frame_error` and discard the byte.
- **`rx_busy`:** high in START, DATA and STOP; low in IDLE.
- **Output register:**
  - On handshake (`m_tvalid && m_tready`) with no byte completing, clear `m_tvalid`.
  - On completion while `m_tvalid`=0, or while a handshake occurs in the same cycle: load `m_tdata`, set `m_tvalid`=1, no overrun.
  - On completion while `m_tvalid`=1 and `m_tready`=0: overwrite `m_tdata`, keep `m_tvalid`=1, and pulse `rx_overrun_error` for one cycle.
  - `m_tdata` is stable while `m_tvalid`=1, except during the overrun overwrite.
- **Error independence:** a frame error does not affect `m_tvalid` or `m_tdata`. Frame error and overrun never pulse in the same cycle.
- **Reset** (any time, including mid-frame): FSM to IDLE, counter and shift register to 0, synchroniser flops to 1. A partially received byte is discarded.

## Timing
- **Reset values:** `m_tdata`=0x00, `m_tvalid`=0, `rx_busy`=0, `rx_overrun_error`=0, `rx_frame_error`=0.
- **Reference cycle:** T0 is the first cycle IDLE sees `rxd_s`=0. `rx_busy` rises at T0+1.
- **Sample points:**
  - Start bit: T0+`CLK_DIV/2`.
  - Data bit i (0..7): T0+`CLK_DIV/2`+(i+1)·`CLK_DIV`.
  - Stop bit: T0+`CLK_DIV/2`+9·`CLK_DIV`.
- **Completion (sample cycle S):** `m_tvalid` or `rx_frame_error` asserts at S+1, and `rx_busy` falls at S+1.
- **End-to-end latency:** from the `rxd` falling edge to `m_tvalid` is 2 + `CLK_DIV/2` + 9·`CLK_DIV` + 1 cycles.
- **Next frame:** a new start bit is detectable from S+1 onward. Back-to-back frames with no idle gap are supported.
- **Consumer side:** `m_tvalid` deasserts the cycle after the handshake. Sustained throughput is one byte per frame time with `m_tready` tied high.

## Test plan
All scenarios use `CLK_DIV`=8 at the bench.
- **Single byte:** send 0xA5 with `m_tready`=1 → `m_tdata`=0xA5 and `m_tvalid` high exactly 1 cycle at T0+77. No error pulses. `rx_busy` high T0+1..T0+76.
- **Overrun:** send 0x01 then 0x0D back-to-back with `m_tready`=0 → after byte 2, `rx_overrun_error` pulses once, `m_tdata`=0x0D, `m_tvalid` stays 1. Raising `m_tready` for 1 cycle then clears `m_tvalid`.
- **Frame error:** send 0x3C with stop bit driven 0, then idle, then 0x55 → `rx_frame_error` pulses once, `m_tvalid` stays 0 for 0x3C, then 0x55 is delivered normally.
- **Glitch rejection:** drive `rxd` low for 2 cycles → `rx_busy` pulses briefly. No `m_tvalid`, no errors.
- **Simultaneous accept and complete:** hold 0x11 pending, assert `m_tready` exactly in the cycle 0x22 completes → no overrun, `m_tdata`=0x22, `m_tvalid` stays 1.
- **Reset mid-frame:** assert `rstn`=0 after data bit 3 of 0xFF and hold it through the stop bit → all outputs at reset values. The next frame 0x7E is received correctly.
